// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch/issue stage of the single-issue RV32I datapath. Holds the program
// counter and fetches one instruction word at a time over a request/valid
// handshake. It presents that word to the control unit until the word is
// accepted. It then redirects to the branch target or falls through to PC+4.
// A misaligned branch target parks the unit in TRAP until reset.
//
// Parameters:
//   RESET_PC      PC loaded on reset (word aligned)
//   NOP_WORD      word shown on IWord while no instruction is held
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   IMemReq       out  fetch request to instruction memory (registered)
//   IMemAddr      out  fetch byte address (registered, word aligned)
//   IMemValid     in   memory response valid (sampled only in FETCH)
//   IMemData      in   memory response data
//   IWord         out  instruction presented to the control unit
//   IValid        out  IWord holds a fetched instruction
//   IReady        in   downstream accepts IWord this cycle (sampled in ISSUE)
//   PCSelect      in   branch taken (sampled in ISSUE with IReady)
//   BranchTarget  in   redirect address from the ALU
//   PC            out  address of the instruction on IWord
//   Misaligned    out  sticky fault: a taken branch target was not word aligned
//   RetiredCount  out  instructions accepted since reset, wraps at 2^32
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic [31:0] IWord,
    output logic        IValid,
    input  logic        IReady,
    input  logic        PCSelect,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PC,
    output logic        Misaligned,
    output logic [31:0] RetiredCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t      state,        state_n;
    logic [31:0] fetch_pc,     fetch_pc_n;
    logic [31:0] pc_q,         pc_n;
    logic [31:0] iword_q,      iword_n;
    logic        ivalid_q,     ivalid_n;
    logic        req_q,        req_n;
    logic [31:0] retired_q,    retired_n;
    logic        misaligned_q, misaligned_n;

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        pc_n         = pc_q;
        iword_n      = iword_q;
        ivalid_n     = ivalid_q;
        req_n        = req_q;
        retired_n    = retired_q;
        misaligned_n = misaligned_q;

        case (state)
            IDLE: begin
                // Request goes out on the first edge after reset release.
                state_n = FETCH;
                req_n   = 1'b1;
            end

            FETCH: begin
                // Covers same-cycle responses too: capture happens on any
                // edge that sees the held request together with IMemValid.
                if (IMemValid) begin
                    iword_n  = IMemData;
                    pc_n     = fetch_pc;
                    ivalid_n = 1'b1;
                    req_n    = 1'b0;
                    state_n  = ISSUE;
                end
            end

            ISSUE: begin
                if (IReady) begin
                    // A misaligned branch still retires its own instruction.
                    retired_n = retired_q + 32'd1;
                    iword_n   = NOP_WORD;
                    ivalid_n  = 1'b0;
                    if (PCSelect && (BranchTarget[1:0] != 2'b00)) begin
                        misaligned_n = 1'b1;
                        state_n      = TRAP;
                    end else begin
                        // PC+4 wraps naturally in 32 bits (0xFFFF_FFFC -> 0).
                        fetch_pc_n = PCSelect ? BranchTarget : pc_q + 32'd4;
                        req_n      = 1'b1;
                        state_n    = FETCH;
                    end
                end
            end

            TRAP: begin
                // Everything frozen; only reset leaves this state.
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            pc_q         <= RESET_PC;
            iword_q      <= NOP_WORD;
            ivalid_q     <= 1'b0;
            req_q        <= 1'b0;
            retired_q    <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            pc_q         <= pc_n;
            iword_q      <= iword_n;
            ivalid_q     <= ivalid_n;
            req_q        <= req_n;
            retired_q    <= retired_n;
            misaligned_q <= misaligned_n;
        end
    end

    assign IMemReq      = req_q;
    assign IMemAddr     = fetch_pc;
    assign IWord        = iword_q;
    assign IValid       = ivalid_q;
    assign PC           = pc_q;
    assign Misaligned   = misaligned_q;
    assign RetiredCount = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit with RESET_PC = 0x100. Instruction
// memory is modelled as a pure function of the address. The bench drives
// IMemValid directly, so it decides when a response arrives. A table of
// per-cycle vectors is applied to the DUT:
// {IMemValid, IReady, PCSelect, BranchTarget} -> expected outputs after the
// edge. Hand-written sequences then cover asynchronous reset in mid-fetch
// and in mid-issue.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic [31:0] IWord;
    logic        IValid;
    logic        IReady;
    logic        PCSelect;
    logic [31:0] BranchTarget;
    logic [31:0] PC;
    logic        Misaligned;
    logic [31:0] RetiredCount;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_WORD (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemValid    (IMemValid),
        .IMemData     (IMemData),
        .IWord        (IWord),
        .IValid       (IValid),
        .IReady       (IReady),
        .PCSelect     (PCSelect),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .Misaligned   (Misaligned),
        .RetiredCount (RetiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a distinct word per address, never equal to the NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    assign IMemData = mem_word(IMemAddr);

    typedef struct {
        logic        valid;
        logic        ready;
        logic        sel;
        logic [31:0] target;
        logic        req;
        logic [31:0] addr;
        logic        ivalid;
        logic [31:0] iword;
        logic [31:0] pc;
        logic [31:0] retired;
        logic        mis;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic ready,
                                input logic sel, input logic [31:0] target,
                                input logic req, input logic [31:0] addr,
                                input logic ivalid, input logic [31:0] iword,
                                input logic [31:0] pc, input logic [31:0] retired,
                                input logic mis);
        vec_t v;
        v.valid = valid; v.ready = ready; v.sel = sel; v.target = target;
        v.req = req; v.addr = addr; v.ivalid = ivalid; v.iword = iword;
        v.pc = pc; v.retired = retired; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic iv, input logic [31:0] iw, input logic [31:0] pc,
                             input logic [31:0] ret, input logic mis);
        check({tag, ".IMemReq"},      {31'd0, IMemReq},    {31'd0, req});
        check({tag, ".IMemAddr"},     IMemAddr,            addr);
        check({tag, ".IValid"},       {31'd0, IValid},     {31'd0, iv});
        check({tag, ".IWord"},        IWord,               iw);
        check({tag, ".PC"},           PC,                  pc);
        check({tag, ".RetiredCount"}, RetiredCount,        ret);
        check({tag, ".Misaligned"},   {31'd0, Misaligned}, {31'd0, mis});
    endtask

    vec_t vecs[25];

    initial begin
        //            valid ready sel target          req addr           iv iword                      pc             ret mis
        // Straight-line, same-cycle memory: addresses 0x100,0x104,0x108 on alternate cycles.
        vecs[0]  = mk(1, 1, 0, 32'h0,           1, 32'h100,        0, NOP,                       32'h100,       0, 0); // IDLE->FETCH, valid ignored
        vecs[1]  = mk(1, 1, 0, 32'h0,           0, 32'h100,        1, mem_word(32'h100),         32'h100,       0, 0);
        vecs[2]  = mk(1, 1, 0, 32'h0,           1, 32'h104,        0, NOP,                       32'h100,       1, 0);
        vecs[3]  = mk(1, 1, 0, 32'h0,           0, 32'h104,        1, mem_word(32'h104),         32'h104,       1, 0);
        vecs[4]  = mk(1, 1, 0, 32'h0,           1, 32'h108,        0, NOP,                       32'h104,       2, 0);
        vecs[5]  = mk(1, 1, 0, 32'h0,           0, 32'h108,        1, mem_word(32'h108),         32'h108,       2, 0);
        vecs[6]  = mk(1, 1, 0, 32'h0,           1, 32'h10C,        0, NOP,                       32'h108,       3, 0);
        // Memory slow by 3 cycles: request held.
        vecs[7]  = mk(0, 1, 0, 32'h0,           1, 32'h10C,        0, NOP,                       32'h108,       3, 0);
        vecs[8]  = mk(0, 1, 0, 32'h0,           1, 32'h10C,        0, NOP,                       32'h108,       3, 0);
        vecs[9]  = mk(0, 1, 0, 32'h0,           1, 32'h10C,        0, NOP,                       32'h108,       3, 0);
        vecs[10] = mk(1, 0, 0, 32'h0,           0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        // IReady low for 5 cycles; branch inputs and IMemValid must be ignored.
        vecs[11] = mk(1, 0, 1, 32'h203,         0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        vecs[12] = mk(1, 0, 1, 32'h203,         0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        vecs[13] = mk(0, 0, 1, 32'h200,         0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        vecs[14] = mk(1, 0, 0, 32'h0,           0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        vecs[15] = mk(0, 0, 1, 32'h200,         0, 32'h10C,        1, mem_word(32'h10C),         32'h10C,       3, 0);
        // Taken branch to 0x200.
        vecs[16] = mk(0, 1, 1, 32'h200,         1, 32'h200,        0, NOP,                       32'h10C,       4, 0);
        vecs[17] = mk(1, 0, 0, 32'h0,           0, 32'h200,        1, mem_word(32'h200),         32'h200,       4, 0);
        // Branch to top of address space, then fall through -> wraps to 0.
        vecs[18] = mk(0, 1, 1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC,  0, NOP,                       32'h200,       5, 0);
        vecs[19] = mk(1, 0, 0, 32'h0,           0, 32'hFFFF_FFFC,  1, mem_word(32'hFFFF_FFFC),   32'hFFFF_FFFC, 5, 0);
        vecs[20] = mk(0, 1, 0, 32'h0,           1, 32'h0,          0, NOP,                       32'hFFFF_FFFC, 6, 0);
        vecs[21] = mk(1, 0, 0, 32'h0,           0, 32'h0,          1, mem_word(32'h0),           32'h0,         6, 0);
        // Misaligned target: retires, traps, then frozen.
        vecs[22] = mk(0, 1, 1, 32'h203,         0, 32'h0,          0, NOP,                       32'h0,         7, 1);
        vecs[23] = mk(1, 1, 0, 32'h0,           0, 32'h0,          0, NOP,                       32'h0,         7, 1);
        vecs[24] = mk(1, 1, 1, 32'h400,         0, 32'h0,          0, NOP,                       32'h0,         7, 1);

        rst_n = 1'b0; IMemValid = 1'b0; IReady = 1'b0; PCSelect = 1'b0; BranchTarget = 32'h0;
        #12;
        check_all("reset", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            IMemValid    = vecs[i].valid;
            IReady       = vecs[i].ready;
            PCSelect     = vecs[i].sel;
            BranchTarget = vecs[i].target;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].ivalid,
                      vecs[i].iword, vecs[i].pc, vecs[i].retired, vecs[i].mis);
            @(negedge clk);
        end

        // Reset out of TRAP in the middle of a cycle: immediate return to reset values.
        #2 rst_n = 1'b0;
        #1 check_all("rst_trap", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        // Release with a late IMemValid: first edge only reaches FETCH.
        IMemValid = 1'b1; IReady = 1'b0; PCSelect = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("rel_late_valid", 1'b1, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        IMemValid = 1'b0;
        @(posedge clk); #1;
        check_all("fetch_wait", 1'b1, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        // Reset during FETCH while IMemValid pulses.
        @(negedge clk);
        IMemValid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("rst_fetch", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(posedge clk); #1;
        check_all("rst_fetch_hold", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; IReady = 1'b1;
        @(posedge clk); #1;  // IDLE -> FETCH
        @(negedge clk);
        @(posedge clk); #1;  // capture
        check_all("refetch", 1'b0, RST_PC, 1'b1, mem_word(RST_PC), RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        IReady = 1'b0;
        @(posedge clk); #1;
        // Reset during ISSUE clears the held instruction and the count.
        @(negedge clk);
        IReady = 1'b1;
        @(posedge clk); #1;
        check("retire_before_rst", RetiredCount, 32'd1);
        @(negedge clk);
        IMemValid = 1'b1;
        @(posedge clk); #1;
        check("issue_before_rst", {31'd0, IValid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all("rst_issue", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
